// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, ALU opcodes and the decoded-instruction record
// passed from decode into the id/ex pipeline stage.
package rv32i_pkg;
    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 4;
    localparam int REG_AW   = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef struct packed {
        alu_op_e           alu_op;
        logic [REG_AW-1:0] rs1_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [REG_AW-1:0] rs2_addr;
        logic [XLEN-1:0]   rs2_data;
        logic              use_imm;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd_addr;
        logic              rd_we;
    } id_ex_t;
endpackage

// File: rtl/id_ex_fwd_mux.sv
// id_ex_fwd_mux: replaces the rs1/rs2 data of one decoded entry with the
// writeback value when the writeback destination matches its source index.
module id_ex_fwd_mux
    import rv32i_pkg::*;
(
    input  id_ex_t            i_entry,
    input  logic              i_wb_rd_we,
    input  logic [REG_AW-1:0] i_wb_rd_addr,
    input  logic [XLEN-1:0]   i_wb_data,
    output id_ex_t            o_entry
);
    logic w_hit;
    assign w_hit = i_wb_rd_we && (i_wb_rd_addr != '0);

    always_comb begin
        o_entry = i_entry;
        if (w_hit && i_wb_rd_addr == i_entry.rs1_addr) o_entry.rs1_data = i_wb_data;
        // with use_imm set operand_b comes from imm, so rs2 is left alone
        if (w_hit && !i_entry.use_imm && i_wb_rd_addr == i_entry.rs2_addr) o_entry.rs2_data = i_wb_data;
    end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute register with a 2-entry skid buffer and sync flush.
// Define ID_EX_FORWARD_EN to forward writeback data into incoming and held entries.
module id_ex_stage
    import rv32i_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALU_OP_W-1:0] id_alu_op,
    input  logic [REG_AW-1:0]   id_rs1_addr,
    input  logic [REG_AW-1:0]   id_rs2_addr,
    input  logic [XLEN-1:0]     id_rs1_data,
    input  logic [XLEN-1:0]     id_rs2_data,
    input  logic [XLEN-1:0]     id_imm,
    input  logic                id_use_imm,
    input  logic [REG_AW-1:0]   id_rd_addr,
    input  logic                id_rd_we,
    input  logic                wb_rd_we,
    input  logic [REG_AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0]     wb_data,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [XLEN-1:0]     operand_a,
    output logic [XLEN-1:0]     operand_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [REG_AW-1:0]   ex_rd_addr,
    output logic                ex_rd_we
);
    id_ex_t            w_in_raw, w_in, w_out_f, w_skid_f;
    id_ex_t            r_out, r_skid;
    logic              r_out_valid, r_skid_valid;
    logic              w_acc, w_to_skid;
    logic [REG_AW-1:0] w_rs1_a, w_rs2_a;

    assign w_in_raw = '{alu_op: alu_op_e'(id_alu_op), rs1_addr: w_rs1_a, rs1_data: id_rs1_data,
                        rs2_addr: w_rs2_a, rs2_data: id_rs2_data, use_imm: id_use_imm,
                        imm: id_imm, rd_addr: id_rd_addr, rd_we: id_rd_we};

`ifdef ID_EX_FORWARD_EN
    assign w_rs1_a = id_rs1_addr;
    assign w_rs2_a = id_rs2_addr;
    id_ex_fwd_mux u_fwd_in (.i_entry(w_in_raw), .i_wb_rd_we(wb_rd_we), .i_wb_rd_addr(wb_rd_addr),
                            .i_wb_data(wb_data), .o_entry(w_in));
    id_ex_fwd_mux u_fwd_out (.i_entry(r_out), .i_wb_rd_we(wb_rd_we), .i_wb_rd_addr(wb_rd_addr),
                             .i_wb_data(wb_data), .o_entry(w_out_f));
    id_ex_fwd_mux u_fwd_skid (.i_entry(r_skid), .i_wb_rd_we(wb_rd_we), .i_wb_rd_addr(wb_rd_addr),
                              .i_wb_data(wb_data), .o_entry(w_skid_f));
`else
    logic w_unused;
    assign w_rs1_a  = '0;
    assign w_rs2_a  = '0;
    assign w_in     = w_in_raw;
    assign w_out_f  = r_out;
    assign w_skid_f = r_skid;
    assign w_unused = ^{wb_rd_we, wb_rd_addr, wb_data, id_rs1_addr, id_rs2_addr,
                        r_out.rs1_addr, r_out.rs2_addr, r_skid.rs1_addr, r_skid.rs2_addr};
`endif

    assign w_acc     = id_valid && !r_skid_valid;
    assign w_to_skid = w_acc && r_out_valid && !ex_ready;

    // skid valid implies output valid, so ex_ready alone marks a transfer from FULL
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out        <= '0;
            r_skid       <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            r_out_valid  <= r_skid_valid || w_acc || (r_out_valid && !ex_ready);
            r_skid_valid <= r_skid_valid ? !ex_ready : w_to_skid;
            r_out        <= (r_skid_valid && ex_ready) ? w_skid_f :
                            (w_acc && (!r_out_valid || ex_ready)) ? w_in :
                            r_out_valid ? w_out_f : r_out;
            r_skid       <= w_to_skid ? w_in : r_skid_valid ? w_skid_f : r_skid;
        end
    end

    assign id_ready   = !r_skid_valid;
    assign ex_valid   = r_out_valid;
    assign operand_a  = r_out.rs1_data;
    assign operand_b  = r_out.use_imm ? r_out.imm : r_out.rs2_data;
    assign alu_op     = r_out.alu_op;
    assign ex_rd_addr = r_out.rd_addr;
    assign ex_rd_we   = r_out.rd_we;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a queue model
// of the stage (queue holds accepted, not yet transferred beats; at most two).
module tb_id_ex_stage;
    import rv32i_pkg::*;

    logic        clk = 0, rst_n = 0, flush = 0, id_valid = 0, ex_ready = 0;
    logic        id_use_imm = 0, id_rd_we = 0, wb_rd_we = 0;
    logic [3:0]  id_alu_op = 0;
    logic [4:0]  id_rs1_addr = 0, id_rs2_addr = 0, id_rd_addr = 0, wb_rd_addr = 0;
    logic [31:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0, wb_data = 0;
    logic        id_ready, ex_valid, ex_rd_we;
    logic [31:0] operand_a, operand_b;
    logic [3:0]  alu_op;
    logic [4:0]  ex_rd_addr;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_op(id_alu_op), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_use_imm(id_use_imm), .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
        .wb_rd_we(wb_rd_we), .wb_rd_addr(wb_rd_addr), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .operand_a(operand_a), .operand_b(operand_b),
        .alu_op(alu_op), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  a1, a2, rd;
        logic [31:0] d1, d2, imm;
        logic        ui, we;
    } beat_t;

    beat_t q[$];
    int n_tests = 0, n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic beat_t fwd(beat_t b);
        beat_t r = b;
`ifdef ID_EX_FORWARD_EN
        if (wb_rd_we && wb_rd_addr != 0) begin
            if (wb_rd_addr == b.a1) r.d1 = wb_data;
            if (!b.ui && wb_rd_addr == b.a2) r.d2 = wb_data;
        end
`endif
        return r;
    endfunction

    // model: flush empties, otherwise held beats see writeback, head leaves on ex_ready, input joins if room
    always @(posedge clk or negedge rst_n) begin : model
        beat_t b;
        bit acc, xfer;
        if (!rst_n || flush) q.delete();
        else begin
            acc  = id_valid && q.size() < 2;
            xfer = q.size() > 0 && ex_ready;
            foreach (q[i]) q[i] = fwd(q[i]);
            if (xfer) void'(q.pop_front());
            if (acc) begin
                b = '{op: id_alu_op, a1: id_rs1_addr, a2: id_rs2_addr, rd: id_rd_addr,
                      d1: id_rs1_data, d2: id_rs2_data, imm: id_imm, ui: id_use_imm, we: id_rd_we};
                q.push_back(fwd(b));
            end
        end
    end

    always @(negedge clk) if (rst_n) begin
        chk("ex_valid", 32'(ex_valid), 32'(q.size() > 0));
        chk("id_ready", 32'(id_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            chk("operand_a", operand_a, q[0].d1);
            chk("operand_b", operand_b, q[0].ui ? q[0].imm : q[0].d2);
            chk("alu_op", 32'(alu_op), 32'(q[0].op));
            chk("rd_addr", 32'(ex_rd_addr), 32'(q[0].rd));
            chk("rd_we", 32'(ex_rd_we), 32'(q[0].we));
        end
    end

    task automatic rand_beat(input logic [31:0] d1);
        id_alu_op   = 4'($urandom_range(9));
        id_rs1_addr = 5'($urandom_range(3));
        id_rs2_addr = 5'($urandom_range(3));
        id_rd_addr  = 5'($urandom_range(31));
        id_rs1_data = d1;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_use_imm  = 1'($urandom_range(1));
        id_rd_we    = 1'($urandom_range(1));
    endtask

    initial begin
        logic [31:0] exp5;
`ifdef ID_EX_FORWARD_EN
        exp5 = 32'hDEADBEEF;
`else
        exp5 = 32'h11111111;
`endif
        repeat (3) @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_id_ready", 32'(id_ready), 1);
        chk("rst_opa", operand_a, 0);
        chk("rst_opb", operand_b, 0);
        chk("rst_alu_op", 32'(alu_op), 0);
        chk("rst_rd", 32'({ex_rd_we, ex_rd_addr}), 0);
        rst_n = 1;

        // single ADD beat
        id_valid = 1; id_alu_op = ALU_ADD; id_rs1_addr = 1; id_rs2_addr = 2;
        id_rs1_data = 5; id_rs2_data = 7; id_use_imm = 0; id_rd_addr = 9; id_rd_we = 1; ex_ready = 1;
        @(negedge clk);
        chk("t1_valid", 32'(ex_valid), 1);
        chk("t1_opa", operand_a, 5);
        chk("t1_opb", operand_b, 7);

        // back-to-back stream
        for (int k = 0; k < 4; k++) begin
            rand_beat(100 + k);
            @(negedge clk);
            chk("t2_ready", 32'(id_ready), 1);
            chk("t2_opa", operand_a, 100 + k);
        end
        id_valid = 0;
        repeat (2) @(negedge clk);

        // backpressure fills the skid, third beat refused
        ex_ready = 0;
        for (int k = 0; k < 3; k++) begin
            rand_beat(200 + k);
            id_valid = 1;
            @(negedge clk);
            chk("t3_opa_stable", operand_a, 200);
            if (k >= 1) chk("t3_ready_low", 32'(id_ready), 0);
        end
        id_valid = 0; ex_ready = 1;
        @(negedge clk);
        chk("t3_second", operand_a, 201);
        @(negedge clk);
        chk("t3_drained", 32'(ex_valid), 0);

        // flush from FULL with a simultaneous offer and transfer
        ex_ready = 0; id_valid = 1;
        rand_beat(300); @(negedge clk);
        rand_beat(301); @(negedge clk);
        chk("t4_full", 32'(id_ready), 0);
        rand_beat(302); flush = 1; ex_ready = 1;
        @(negedge clk);
        chk("t4_valid", 32'(ex_valid), 0);
        chk("t4_ready", 32'(id_ready), 1);
        flush = 0; id_valid = 0;
        @(negedge clk);
        chk("t4_still_empty", 32'(ex_valid), 0);

        // forwarding into a held output entry
        ex_ready = 0; id_valid = 1; id_use_imm = 0;
        id_rs1_addr = 3; id_rs1_data = 32'h11111111; id_rs2_addr = 5; id_rs2_data = 32'h55;
        @(negedge clk);
        chk("t5_captured", operand_a, 32'h11111111);
        id_valid = 0; wb_rd_we = 1; wb_rd_addr = 3; wb_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("t5_fwd", operand_a, exp5);
        wb_rd_addr = 0; wb_data = 32'h12345678;
        @(negedge clk);
        chk("t5_x0", operand_a, exp5);
        chk("t5_opb", operand_b, 32'h55);
        wb_rd_we = 0; ex_ready = 1;
        @(negedge clk);

        // immediate wins over a matching rs2 writeback
        ex_ready = 0; id_valid = 1; id_use_imm = 1; id_imm = 32'hFFFFF800;
        id_rs1_addr = 6; id_rs2_addr = 4; id_rs2_data = 32'h22;
        wb_rd_we = 1; wb_rd_addr = 4; wb_data = 32'hAAAA5555;
        @(negedge clk);
        chk("t6_imm_in", operand_b, 32'hFFFFF800);
        id_valid = 0;
        @(negedge clk);
        chk("t6_imm_held", operand_b, 32'hFFFFF800);
        wb_rd_we = 0; ex_ready = 1;
        repeat (2) @(negedge clk);

        // async reset while FULL
        ex_ready = 0; id_valid = 1;
        rand_beat(400); @(negedge clk);
        rand_beat(401); @(negedge clk);
        id_valid = 0;
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 32'(ex_valid), 0);
        chk("arst_ready", 32'(id_ready), 1);
        chk("arst_opa", operand_a, 0);
        @(negedge clk);
        rst_n = 1;

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rand_beat($urandom);
            id_valid   = ($urandom_range(3) != 0);
            ex_ready   = ($urandom_range(2) != 0);
            flush      = ($urandom_range(31) == 0);
            wb_rd_we   = 1'($urandom_range(1));
            wb_rd_addr = 5'($urandom_range(3));
            wb_data    = $urandom;
            @(negedge clk);
        end
        id_valid = 0; flush = 0; wb_rd_we = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
